// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Imported by the interface, the arbiter and its address generator.
package dmem_arb_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;
    localparam int CNT_W  = 9;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DONE
    } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Core, host and memory-side signals of the data-memory arbiter.
// slave is the arbiter's view, master is the surrounding system's view.
interface dmem_arbiter_if #(
    parameter int AW = dmem_arb_pkg::AW_DEF,
    parameter int DW = dmem_arb_pkg::DW_DEF
);
    logic          core_rd;
    logic          core_wr;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic [DW-1:0] core_rdata;
    logic          core_stall;

    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [7:0]    host_len;
    logic          host_wvalid;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          host_done;

    logic [AW-1:0] mem_addr;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  core_rd, core_wr, core_addr, core_wdata,
        output core_rdata, core_stall,
        input  host_req, host_we, host_addr, host_len,
        input  host_wvalid, host_wdata,
        output host_gnt, host_rvalid, host_rdata, host_done,
        output mem_addr, mem_read, mem_write, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_rd, core_wr, core_addr, core_wdata,
        input  core_rdata, core_stall,
        output host_req, host_we, host_addr, host_len,
        output host_wvalid, host_wdata,
        input  host_gnt, host_rvalid, host_rdata, host_done,
        input  mem_addr, mem_read, mem_write, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter_burst_addr_gen.sv
// Host burst address and remaining-beat counter.
// A length of 0 loads 256 beats; the address wraps at 2**AW.
module burst_addr_gen
    import dmem_arb_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    len_i,
    input  logic          step_i,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);

    logic [AW-1:0]    addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load on grant, advance one position per performed beat.
    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            addr_d = addr_i;
            cnt_d  = (len_i == 8'd0) ? CNT_W'(256) : {1'b0, len_i};
        end else if (step_i) begin
            addr_d = addr_q + AW'(1);
            cnt_d  = cnt_q - CNT_W'(1);
        end
    end

    // Address and counter registers, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data memory between the core and a burst host port.
// Core is a zero-latency pass-through whenever no host burst runs.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STARVE_MAX = 4
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);

    localparam logic [3:0] WAIT_MAX = 4'(STARVE_MAX);

    arb_state_t    state_q, state_d;
    logic [3:0]    wait_q, wait_d;
    logic          we_q, we_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          core_acc;
    logic          grant;
    logic          beat;
    logic          last;
    logic [AW-1:0] baddr;

    logic [AW-1:0] m_addr;
    logic          m_read;
    logic          m_write;
    logic [DW-1:0] m_wdata;
    logic          c_stall;

    assign core_acc = bus.core_rd | bus.core_wr;
    assign grant    = (state_q == IDLE) && bus.host_req &&
                      (!core_acc || (wait_q == WAIT_MAX));
    assign beat     = (state_q == BURST) &&
                      (we_q ? bus.host_wvalid : 1'b1);

    burst_addr_gen #(
        .AW(AW)
    ) u_agen (
        .clk_i (clk),
        .rst_ni(reset),
        .load_i(grant),
        .addr_i(bus.host_addr),
        .len_i (bus.host_len),
        .step_i(beat),
        .addr_o(baddr),
        .last_o(last)
    );

    // Next state, memory port steering and core stall.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        m_addr   = bus.core_addr;
        m_read   = bus.core_rd;
        m_write  = bus.core_wr;
        m_wdata  = bus.core_wdata;
        c_stall  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = BURST;
                    we_d    = bus.host_we;
                end
            end
            BURST: begin
                m_addr  = baddr;
                m_read  = !we_q;
                // A beat caught by reset must not reach memory.
                m_write = we_q & bus.host_wvalid & reset;
                m_wdata = bus.host_wdata;
                c_stall = core_acc;
                if (beat && last) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Starvation counter and registered host read beat.
    always_comb begin
        wait_d   = wait_q;
        rvalid_d = beat & !we_q;
        rdata_d  = rdata_q;
        if (!bus.host_req || grant) begin
            wait_d = '0;
        end else if ((state_q == IDLE) && core_acc &&
                     (wait_q != WAIT_MAX)) begin
            wait_d = wait_q + 4'd1;
        end
        if (rvalid_d) rdata_d = bus.mem_rdata;
    end

    // State and control registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            we_q     <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            we_q     <= we_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.mem_addr    = m_addr;
    assign bus.mem_read    = m_read;
    assign bus.mem_write   = m_write;
    assign bus.mem_wdata   = m_wdata;
    assign bus.core_rdata  = bus.mem_rdata;
    assign bus.core_stall  = c_stall;
    assign bus.host_gnt    = (state_q == BURST);
    assign bus.host_done   = (state_q == DONE);
    assign bus.host_rvalid = rvalid_q;
    assign bus.host_rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a combinational-read memory.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
module tb_dmem_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(8), .DW(8)) bus ();

    dmem_arbiter #(
        .AW(8),
        .DW(8),
        .STARVE_MAX(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [7:0] mem [0:255];

    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    assign bus.mem_rdata = mem[bus.mem_addr];

    function automatic logic [7:0] pat(input int i);
        logic [7:0] v;
        v = 8'(i);
        if (i == 0) return 8'h11;
        if (i == 1) return 8'h22;
        if (i == 2) return 8'h33;
        return v ^ 8'h5C;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.core_rd     = 1'b0;
        bus.core_wr     = 1'b0;
        bus.core_addr   = 8'h00;
        bus.core_wdata  = 8'h00;
        bus.host_req    = 1'b0;
        bus.host_we     = 1'b0;
        bus.host_addr   = 8'h00;
        bus.host_len    = 8'h00;
        bus.host_wvalid = 1'b0;
        bus.host_wdata  = 8'h00;
    endtask

    task automatic core_read(input logic [7:0] a, input logic [7:0] e,
                             input string tag);
        bus.core_rd   = 1'b1;
        bus.core_addr = a;
        #1;
        chk(tag, int'(bus.core_rdata), int'(e));
        cyc();
        bus.core_rd = 1'b0;
    endtask

    initial begin
        int stall_seen;
        int gcnt;
        int dcnt;
        int dcyc;
        int rcnt;
        int first_g;
        int smis;
        logic [7:0] rfirst;
        logic [7:0] rlast;
        logic       dwith_rv;

        quiet();
        repeat (3) cyc();
        chk("rst_gnt", int'(bus.host_gnt), 0);
        chk("rst_done", int'(bus.host_done), 0);
        chk("rst_rvalid", int'(bus.host_rvalid), 0);
        chk("rst_rdata", int'(bus.host_rdata), 0);
        chk("rst_stall", int'(bus.core_stall), 0);
        reset = 1'b1;
        cyc();

        // Preload memory through the core path.
        stall_seen = 0;
        for (int i = 0; i < 256; i++) begin
            bus.core_wr    = 1'b1;
            bus.core_addr  = 8'(i);
            bus.core_wdata = pat(i);
            #1;
            if (bus.core_stall) stall_seen++;
            cyc();
        end
        quiet();

        // Core only: write then same-cycle read back.
        bus.core_wr    = 1'b1;
        bus.core_addr  = 8'h10;
        bus.core_wdata = 8'h5A;
        #1;
        if (bus.core_stall) stall_seen++;
        cyc();
        bus.core_wr = 1'b0;
        bus.core_rd = 1'b1;
        #1;
        chk("core_rd_5a", int'(bus.core_rdata), 'h5A);
        if (bus.core_stall) stall_seen++;
        cyc();
        bus.core_rd    = 1'b0;
        bus.core_wr    = 1'b1;
        bus.core_wdata = 8'hC3;
        #1;
        cyc();
        bus.core_wr = 1'b0;
        bus.core_rd = 1'b1;
        #1;
        chk("core_rd_c3", int'(bus.core_rdata), 'hC3);
        if (bus.core_stall) stall_seen++;
        chk("core_no_stall", stall_seen, 0);
        cyc();
        quiet();

        // Host read burst of 3 from 0x00.
        bus.host_req  = 1'b1;
        bus.host_addr = 8'h00;
        bus.host_len  = 8'd3;
        #1;
        chk("rd_gnt_c0", int'(bus.host_gnt), 0);
        cyc();
        bus.host_req = 1'b0;
        #1;
        chk("rd_gnt_c1", int'(bus.host_gnt), 1);
        chk("rd_rv_c1", int'(bus.host_rvalid), 0);
        cyc();
        chk("rd_rv_c2", int'(bus.host_rvalid), 1);
        chk("rd_d_c2", int'(bus.host_rdata), 'h11);
        cyc();
        chk("rd_rv_c3", int'(bus.host_rvalid), 1);
        chk("rd_d_c3", int'(bus.host_rdata), 'h22);
        chk("rd_done_c3", int'(bus.host_done), 0);
        cyc();
        chk("rd_rv_c4", int'(bus.host_rvalid), 1);
        chk("rd_d_c4", int'(bus.host_rdata), 'h33);
        chk("rd_done_c4", int'(bus.host_done), 1);
        chk("rd_gnt_c4", int'(bus.host_gnt), 0);
        cyc();
        chk("rd_rv_c5", int'(bus.host_rvalid), 0);
        chk("rd_done_c5", int'(bus.host_done), 0);

        // Host write burst of 4 from 0xFE, wvalid low on 2nd cycle.
        bus.host_req  = 1'b1;
        bus.host_we   = 1'b1;
        bus.host_addr = 8'hFE;
        bus.host_len  = 8'd4;
        gcnt = 0;
        dcnt = 0;
        dcyc = 0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            bus.host_req    = 1'b0;
            bus.host_wvalid = (k == 1) || (k >= 3 && k <= 5);
            bus.host_wdata  = (k == 1) ? 8'hA0 : 8'(8'h9E + k);
            #1;
            if (bus.host_gnt) gcnt++;
            if (bus.host_done) begin
                dcnt++;
                dcyc = k;
            end
        end
        quiet();
        chk("wr_gnt_cycles", gcnt, 5);
        chk("wr_done_count", dcnt, 1);
        chk("wr_done_cycle", dcyc, 6);
        core_read(8'hFE, 8'hA0, "wr_mem_fe");
        core_read(8'hFF, 8'hA1, "wr_mem_ff");
        core_read(8'h00, 8'hA2, "wr_mem_00");
        core_read(8'h01, 8'hA3, "wr_mem_01");
        core_read(8'h02, 8'h33, "wr_mem_02");

        // Starvation: core busy every cycle, host request held.
        first_g = 0;
        smis    = 0;
        dcyc    = 0;
        for (int n = 1; n <= 12; n++) begin
            cyc();
            bus.core_rd   = 1'b1;
            bus.core_addr = 8'h20;
            bus.host_req  = 1'b1;
            bus.host_addr = 8'h40;
            bus.host_len  = 8'd2;
            #1;
            if (bus.host_gnt && first_g == 0) first_g = n;
            if (bus.core_stall !== bus.host_gnt) smis++;
            if (bus.host_done && dcyc == 0) dcyc = n;
            if (n == 5) begin
                chk("starve_c5_stall", int'(bus.core_stall), 0);
                chk("starve_c5_rdata", int'(bus.core_rdata), 'h7C);
            end
        end
        quiet();
        chk("starve_first_gnt", first_g, 6);
        chk("starve_stall_eq_gnt", smis, 0);
        chk("starve_done_cycle", dcyc, 8);
        cyc();

        // Length 0: 256-beat read burst from 0x80.
        bus.host_req  = 1'b1;
        bus.host_addr = 8'h80;
        bus.host_len  = 8'd0;
        gcnt     = 0;
        dcnt     = 0;
        rcnt     = 0;
        rfirst   = 8'h00;
        rlast    = 8'h00;
        dwith_rv = 1'b0;
        for (int k = 1; k <= 270; k++) begin
            cyc();
            bus.host_req = 1'b0;
            #1;
            if (bus.host_gnt) gcnt++;
            if (bus.host_rvalid) begin
                if (rcnt == 0) rfirst = bus.host_rdata;
                rlast = bus.host_rdata;
                rcnt++;
            end
            if (bus.host_done) begin
                dcnt++;
                dwith_rv = bus.host_rvalid;
            end
        end
        chk("len0_gnt_cycles", gcnt, 256);
        chk("len0_beats", rcnt, 256);
        chk("len0_first", int'(rfirst), 'hDC);
        chk("len0_last", int'(rlast), 'h23);
        chk("len0_done_count", dcnt, 1);
        chk("len0_done_with_rv", int'(dwith_rv), 1);

        // Reset asserted on beat 2 of a 4-beat write burst at 0x30.
        bus.host_req  = 1'b1;
        bus.host_we   = 1'b1;
        bus.host_addr = 8'h30;
        bus.host_len  = 8'd4;
        cyc();
        bus.host_req    = 1'b0;
        bus.host_wvalid = 1'b1;
        bus.host_wdata  = 8'hB0;
        cyc();
        bus.host_wdata = 8'hB1;
        cyc();
        bus.host_wdata = 8'hB2;
        reset = 1'b0;
        #1;
        chk("rstb_gnt_before", int'(bus.host_gnt), 1);
        cyc();
        reset = 1'b1;
        quiet();
        #1;
        chk("rstb_gnt_after", int'(bus.host_gnt), 0);
        chk("rstb_done_after", int'(bus.host_done), 0);
        chk("rstb_rvalid", int'(bus.host_rvalid), 0);
        cyc();
        chk("rstb_gnt_next", int'(bus.host_gnt), 0);
        chk("rstb_done_next", int'(bus.host_done), 0);
        core_read(8'h30, 8'hB0, "rstb_mem_30");
        core_read(8'h31, 8'hB1, "rstb_mem_31");
        core_read(8'h32, 8'h6E, "rstb_mem_32");
        core_read(8'h33, 8'h6F, "rstb_mem_33");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
